// File: rtl/touch_spi_reader.sv
// XPT2046-class touch reader: debounced pen, X/Y SPI conversions,
// panel-space scaling and a windowed tap counter.
module touch_spi_reader #(
  parameter int CLK_DIV    = 25,
  parameter int DEBOUNCE   = 50000,
  parameter int TAP_WINDOW = 25000000,
  parameter int X_MAX      = 799,
  parameter int Y_MAX      = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pen_irq_n,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic [9:0] tor_x,
  output logic [8:0] tor_y,
  output logic       valid,
  output logic [1:0] clcount
);

  localparam int DW  = $clog2(CLK_DIV);
  localparam int BW  = $clog2(DEBOUNCE) + 1;
  localparam int TWW = $clog2(TAP_WINDOW) + 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  DB_LAST  = BW'(DEBOUNCE - 1);
  localparam logic [TWW-1:0] TW_LAST  = TWW'(TAP_WINDOW - 1);
  localparam logic [9:0]     XM       = X_MAX[9:0];
  localparam logic [8:0]     YM       = Y_MAX[8:0];

  typedef enum logic [2:0] {
    IDLE,
    CONV_X,
    GAP,
    CONV_Y,
    UPDATE
  } state_t;

  state_t state, state_n;

  logic          s1, s2;
  logic [BW-1:0] db_cnt;
  logic          pen_down, pen_q;
  logic          press, release_e;

  logic [DW-1:0] div;
  logic [5:0]    h;
  logic          tick_end, conv;
  logic [11:0]   sh;
  logic [9:0]    sx, xs;
  logic [8:0]    sy, ys;
  logic          gap_y, rel_seen;
  logic [7:0]    cmd;

  logic           run;
  logic [TWW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= pen_irq_n;
      s2 <= s1;
    end
  end

  // pen_down flips only after DEBOUNCE consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      pen_down <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      pen_q <= pen_down;
      if (~s2 == pen_down) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        pen_down <= ~s2;
      end else begin
        db_cnt <= db_cnt + BW'(1);
      end
    end
  end

  assign press     = pen_down & ~pen_q;
  assign release_e = pen_q & ~pen_down;

  assign conv     = (state == CONV_X) || (state == CONV_Y);
  assign tick_end = (div == DIV_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (pen_down) state_n = CONV_X;
      CONV_X, CONV_Y:
        if (tick_end && h == 6'd47) state_n = GAP;
      GAP:
        if (tick_end && h == 6'd1) begin
          if (rel_seen || !pen_down) state_n = IDLE;
          else if (gap_y)            state_n = UPDATE;
          else                       state_n = CONV_Y;
        end
      UPDATE:
        state_n = pen_down ? CONV_X : IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // h counts SCLK half-periods; odd halves are SCLK high
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
    end else if (state_n != state || state == IDLE ||
                 state == UPDATE) begin
      div <= '0;
      h   <= '0;
    end else if (tick_end) begin
      div <= '0;
      h   <= h + 6'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  // only r[14:3] is kept: rising edges of SCLK cycles 10..21
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else if (conv && tick_end && !h[0] &&
                 h >= 6'd18 && h <= 6'd40) begin
      sh <= {sh[10:0], spi_miso};
    end
  end

  assign xs = (sh[11:2] > XM) ? XM : sh[11:2];
  assign ys = (sh[11:3] > YM) ? YM : sh[11:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      sx    <= '0;
      sy    <= '0;
      gap_y <= 1'b0;
    end else begin
      if (state == CONV_X) gap_y <= 1'b0;
      if (state == CONV_Y) gap_y <= 1'b1;
      if (state == CONV_X && state_n == GAP) sx <= xs;
      if (state == CONV_Y && state_n == GAP) sy <= ys;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rel_seen <= 1'b0;
    else if (state == IDLE || state == UPDATE)
      rel_seen <= 1'b0;
    else if (!pen_down)
      rel_seen <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tor_x <= '0;
      tor_y <= '0;
    end else begin
      valid <= 1'b0;
      if (state == UPDATE && pen_down && !rel_seen) begin
        valid <= 1'b1;
        tor_x <= sx;
        tor_y <= sy;
      end
    end
  end

  // press is checked first so it beats a same-cycle window expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      clcount <= 2'd0;
      run     <= 1'b0;
      tcnt    <= '0;
    end else if (press) begin
      run  <= 1'b0;
      tcnt <= '0;
      if (!run)                 clcount <= 2'd1;
      else if (clcount != 2'd3) clcount <= clcount + 2'd1;
    end else if (release_e) begin
      run  <= 1'b1;
      tcnt <= '0;
    end else if (run) begin
      if (tcnt == TW_LAST) begin
        run     <= 1'b0;
        tcnt    <= '0;
        clcount <= 2'd0;
      end else begin
        tcnt <= tcnt + TWW'(1);
      end
    end
  end

  assign cmd      = (state == CONV_X) ? 8'hD0 : 8'h90;
  assign spi_cs_n = ~conv;
  assign spi_sclk = conv & h[0];
  assign spi_mosi = conv && (h < 6'd16) && cmd[3'd7 - h[3:1]];

endmodule

// File: tb/tb_touch_spi_reader.sv
// Directed bench for touch_spi_reader with a behavioural
// XPT2046 slave answering X/Y commands on the SPI bus.
module tb_touch_spi_reader;

  localparam int CD   = 2;
  localparam int DB   = 8;
  localparam int TW   = 3000;
  localparam int PAIR = 100 * CD + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pen_irq_n = 1'b1;
  logic       spi_miso = 1'b0;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic [9:0] tor_x;
  logic [8:0] tor_y;
  logic       valid;
  logic [1:0] clcount;

  touch_spi_reader #(
    .CLK_DIV(CD), .DEBOUNCE(DB), .TAP_WINDOW(TW),
    .X_MAX(799), .Y_MAX(479)
  ) dut (
    .clk(clk), .reset(reset), .pen_irq_n(pen_irq_n),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .tor_x(tor_x), .tor_y(tor_y), .valid(valid),
    .clcount(clcount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int nvalid = 0;
  always @(negedge clk) if (valid === 1'b1) nvalid++;

  logic [11:0] rawx = 12'h0;
  logic [11:0] rawy = 12'h0;
  logic        pcs = 1'b1;
  logic        psclk = 1'b0;
  logic [7:0]  cmdsh = 8'h0;
  logic [15:0] w;
  int          nr = 0, nf = 0, cs_falls = 0, frames = 0;
  logic [7:0]  cmd_log[$];
  int          nr_log[$];

  // slave: shifts MOSI on SCLK rise, drives MISO on SCLK fall
  always @(spi_cs_n or spi_sclk) begin
    if (!spi_cs_n && pcs) begin
      nr = 0; nf = 0; cmdsh = 8'h0; spi_miso = 1'b0;
      cs_falls++;
    end else if (spi_cs_n && !pcs) begin
      frames++;
      cmd_log.push_back(cmdsh);
      nr_log.push_back(nr);
      spi_miso = 1'b0;
    end else if (!spi_cs_n && spi_sclk && !psclk) begin
      nr++;
      if (nr <= 8) cmdsh = {cmdsh[6:0], spi_mosi};
    end else if (!spi_cs_n && !spi_sclk && psclk) begin
      nf++;
      if (nf >= 8 && nf <= 23) begin
        w = {1'b0, (cmdsh == 8'hD0) ? rawx : rawy, 3'b000};
        spi_miso = w[15 - (nf - 8)];
      end else begin
        spi_miso = 1'b0;
      end
    end
    pcs = spi_cs_n;
    psclk = spi_sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc, output bit ok,
                            output int tv);
    ok = 1'b0;
    tv = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        tv = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pen_irq_n = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (spi_cs_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_cs: got %b want 1", spi_cs_n);
    end
    n_checks++;
    if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_spi: sclk %b mosi %b want 0 0",
               spi_sclk, spi_mosi);
    end
    n_checks++;
    if (tor_x !== 10'd0 || tor_y !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_xy: got %0d,%0d want 0,0", tor_x, tor_y);
    end
    n_checks++;
    if (valid !== 1'b0 || clcount !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_vc: valid %b clcount %0d want 0 0",
               valid, clcount);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int fb;
    rawx = 12'h800;
    rawy = 12'h400;
    fb = cs_falls;
    pen_irq_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL mid_cs_assert: got timeout want cs low");
    end
    tick(11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_spi: cs %b sclk %b want 1 0",
               spi_cs_n, spi_sclk);
    end
    n_checks++;
    if (clcount !== 2'd0 || spi_mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_out: clcount %0d mosi %b want 0 0",
               clcount, spi_mosi);
    end
    pen_irq_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(300);
    n_checks++;
    if (nvalid !== 0) begin
      n_fail++; $display("FAIL mid_no_valid: got %0d want 0", nvalid);
    end
    n_checks++;
    if (cs_falls !== fb + 1) begin
      n_fail++;
      $display("FAIL mid_no_restart: got %0d want %0d",
               cs_falls, fb + 1);
    end
  endtask

  task automatic test_coords;
    bit ok;
    int t0, tv1, tv2, fr, lat;
    rawx = 12'h800;
    rawy = 12'h400;
    fr = frames;
    t0 = cyc;
    pen_irq_n = 1'b0;
    wait_valid(400, ok, tv1);
    lat = tv1 - t0;
    n_checks++;
    if (!ok || lat < 2 + DB + PAIR - 2 || lat > 2 + DB + PAIR + 2) begin
      n_fail++;
      $display("FAIL first_valid_lat: got %0d ok %b want %0d",
               lat, ok, 2 + DB + PAIR);
    end
    n_checks++;
    if (tor_x !== 10'd512 || tor_y !== 9'd128) begin
      n_fail++;
      $display("FAIL coords: got %0d,%0d want 512,128", tor_x, tor_y);
    end
    n_checks++;
    if (frames < fr + 2 || cmd_log[fr] !== 8'hD0 ||
        cmd_log[fr+1] !== 8'h90) begin
      n_fail++;
      $display("FAIL mosi_cmds: frames %0d want >= %0d (D0,90)",
               frames - fr, 2);
    end
    n_checks++;
    if (frames < fr + 2 || nr_log[fr] !== 24 || nr_log[fr+1] !== 24) begin
      n_fail++; $display("FAIL sclk_count: got short frame want 24");
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_pulse: got %b want 0", valid);
    end
    wait_valid(300, ok, tv2);
    n_checks++;
    if (!ok || tv2 - tv1 !== PAIR) begin
      n_fail++;
      $display("FAIL repeat_period: got %0d ok %b want %0d",
               tv2 - tv1, ok, PAIR);
    end
  endtask

  task automatic test_clamp;
    bit ok;
    int tv;
    rawx = 12'hFFF;
    rawy = 12'hFFF;
    wait_valid(300, ok, tv);
    wait_valid(300, ok, tv);
    n_checks++;
    if (!ok || tor_x !== 10'd799 || tor_y !== 9'd479) begin
      n_fail++;
      $display("FAIL clamp: got %0d,%0d ok %b want 799,479",
               tor_x, tor_y, ok);
    end
    pen_irq_n = 1'b1;
    tick(400);
    n_checks++;
    if (clcount !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_release_cl: got %0d want 1", clcount);
    end
  endtask

  task automatic test_taps;
    int e[4] = '{1, 2, 3, 3};
    int nv;
    tick(TW + 100);
    n_checks++;
    if (clcount !== 2'd0) begin
      n_fail++; $display("FAIL window_clear0: got %0d want 0", clcount);
    end
    nv = nvalid;
    for (int i = 0; i < 4; i++) begin
      pen_irq_n = 1'b0;
      tick(40);
      n_checks++;
      if (clcount !== 2'(e[i])) begin
        n_fail++;
        $display("FAIL tap_press%0d: got %0d want %0d",
                 i, clcount, e[i]);
      end
      pen_irq_n = 1'b1;
      tick(150);
      n_checks++;
      if (clcount !== 2'(e[i])) begin
        n_fail++;
        $display("FAIL tap_release%0d: got %0d want %0d",
                 i, clcount, e[i]);
      end
    end
    n_checks++;
    if (nvalid !== nv) begin
      n_fail++;
      $display("FAIL tap_no_valid: got %0d want %0d", nvalid, nv);
    end
    tick(TW + 100);
    n_checks++;
    if (clcount !== 2'd0) begin
      n_fail++; $display("FAIL window_expire: got %0d want 0", clcount);
    end
    pen_irq_n = 1'b0;
    tick(40);
    n_checks++;
    if (clcount !== 2'd1) begin
      n_fail++; $display("FAIL tap_restart: got %0d want 1", clcount);
    end
    pen_irq_n = 1'b1;
    tick(TW + 100);
  endtask

  task automatic test_glitch;
    int fb;
    fb = cs_falls;
    n_checks++;
    if (clcount !== 2'd0) begin
      n_fail++; $display("FAIL glitch_pre: got %0d want 0", clcount);
    end
    pen_irq_n = 1'b0;
    tick(4);
    pen_irq_n = 1'b1;
    tick(100);
    n_checks++;
    if (cs_falls !== fb) begin
      n_fail++;
      $display("FAIL glitch_cs: got %0d want %0d", cs_falls, fb);
    end
    n_checks++;
    if (clcount !== 2'd0) begin
      n_fail++; $display("FAIL glitch_cl: got %0d want 0", clcount);
    end
  endtask

  task automatic test_release_y;
    bit ok;
    int fb, fr, nv;
    rawx = 12'h800;
    rawy = 12'h400;
    fb = cs_falls;
    fr = frames;
    nv = nvalid;
    pen_irq_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cs_falls >= fb + 2) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rel_y_start: got timeout want CONV_Y");
    end
    pen_irq_n = 1'b1;
    tick(400);
    n_checks++;
    if (frames !== fr + 2 || nr_log[fr+1] !== 24 ||
        cmd_log[fr+1] !== 8'h90) begin
      n_fail++;
      $display("FAIL rel_y_frame: frames %0d want %0d (Y, 24 sclk)",
               frames - fr, 2);
    end
    n_checks++;
    if (nvalid !== nv) begin
      n_fail++;
      $display("FAIL rel_y_valid: got %0d want %0d", nvalid, nv);
    end
    n_checks++;
    if (tor_x !== 10'd799 || tor_y !== 9'd479) begin
      n_fail++;
      $display("FAIL rel_y_hold: got %0d,%0d want 799,479",
               tor_x, tor_y);
    end
    n_checks++;
    if (cs_falls !== fb + 2 || spi_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_y_idle: falls %0d cs %b want %0d 1",
               cs_falls, spi_cs_n, fb + 2);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_coords;
    test_clamp;
    test_taps;
    test_glitch;
    test_release_y;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
